ddr_chan_arbiter: RTL and testbench

- Multi-channel successor to the single-pair DDR write/read request and address generator.
- Arbitrates NCH write channels and NCH read channels onto one DDR user burst port, with writes taking priority over reads.
- Generates a per-channel burst address with a frame-end rule: lock-at-end or wrap-to-base, selectable per channel.
- Sits between the per-channel FIFOs, which stay outside this block and report fill levels, and the DDR burst controller.

---
 rtl/ddr_chan_arbiter_if.sv | 26 ++
 rtl/ddr_chan_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_ddr_chan_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_chan_arbiter_if.sv
// Burst-port bundle between the channel arbiter (master) and the DDR burst controller (slave).
interface ddr_chan_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 25,
  parameter int LW  = 10
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           ddr_wr_req;
  logic           ddr_rd_req;
  logic [AW-1:0]  ddr_addr;
  logic [LW-1:0]  ddr_len;
  logic [CHW-1:0] ddr_ch;
  logic           ddr_wr_finish;
  logic           ddr_rd_finish;

  modport master (
    output ddr_wr_req, ddr_rd_req, ddr_addr, ddr_len, ddr_ch,
    input  ddr_wr_finish, ddr_rd_finish
  );

  modport slave (
    input  ddr_wr_req, ddr_rd_req, ddr_addr, ddr_len, ddr_ch,
    output ddr_wr_finish, ddr_rd_finish
  );
endinterface

// File: rtl/ddr_chan_arbiter.sv
// Write-priority round-robin arbiter for NCH write and NCH read channels onto one DDR burst port,
// with per-channel burst address generation and lock/wrap frame-end handling.
module ddr_chan_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 25,
  parameter int LW  = 10,
  parameter int FW  = 10
) (
  input  logic                clk_ref,
  input  logic                rst,
  input  logic                ddr_init_done,
  input  logic [LW-1:0]       wr_length,
  input  logic [LW-1:0]       rd_length,
  input  logic [NCH-1:0]      wr_load,
  input  logic [NCH-1:0]      rd_load,
  input  logic [NCH*AW-1:0]   wr_addr,
  input  logic [NCH*AW-1:0]   wr_max_addr,
  input  logic [NCH*AW-1:0]   rd_addr,
  input  logic [NCH*AW-1:0]   rd_max_addr,
  input  logic [NCH-1:0]      wrap_mode,
  input  logic [NCH*FW-1:0]   wrf_use,
  input  logic [NCH*FW-1:0]   rdf_use,
  input  logic [NCH-1:0]      data_valid,
  ddr_chan_arbiter_if.master  ddr_bus,
  output logic [NCH-1:0]      frame_write_done,
  output logic [NCH-1:0]      frame_read_done
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = (FW > LW) ? FW : LW;

  typedef enum logic [1:0] {IDLE, ARB, WR_BUSY, RD_BUSY} state_t;
  state_t state;

  logic [AW-1:0]  wr_cur [NCH];
  logic [AW-1:0]  rd_cur [NCH];
  logic [NCH-1:0] wr_load_q, rd_load_q;
  logic [NCH-1:0] wr_pend, rd_pend;
  logic [CHW-1:0] wr_rr_ptr, rd_rr_ptr;

  logic [NCH-1:0] wr_clr, rd_clr;
  logic [NCH-1:0] wr_granted, rd_granted;
  logic [NCH-1:0] wr_elig, rd_elig;
  logic           wr_any, rd_any;
  logic [CHW-1:0] wr_pick, rd_pick;
  logic [AW-1:0]  wr_pick_addr, rd_pick_addr;
  logic [AW-1:0]  fin_base, fin_max, fin_cur;
  logic           fin_reload, fin_wrap, fin_adv;
  logic [AW:0]    fin_sum;

  always_comb begin
    wr_clr       = wr_load & ~wr_load_q;
    rd_clr       = (rd_load & ~rd_load_q) | ~data_valid;
    wr_granted   = '0;
    rd_granted   = '0;
    wr_elig      = '0;
    rd_elig      = '0;
    wr_any       = 1'b0;
    rd_any       = 1'b0;
    wr_pick      = '0;
    rd_pick      = '0;
    wr_pick_addr = '0;
    rd_pick_addr = '0;
    fin_base     = '0;
    fin_max      = '0;
    fin_cur      = '0;
    fin_reload   = 1'b0;
    fin_wrap     = 1'b0;

    for (int unsigned i = 0; i < NCH; i++) begin
      wr_granted[i] = (state == WR_BUSY) && (ddr_bus.ddr_ch == CHW'(i));
      rd_granted[i] = (state == RD_BUSY) && (ddr_bus.ddr_ch == CHW'(i));
      wr_elig[i] = (CW'(wrf_use[i*FW +: FW]) >= CW'(wr_length)) &&
                   (wrap_mode[i] || !frame_write_done[i]);
      rd_elig[i] = data_valid[i] && (CW'(rdf_use[i*FW +: FW]) < CW'(rd_length)) &&
                   (wrap_mode[i] || !frame_read_done[i]);
    end

    // Scan starts at the round-robin pointer; first hit wins.
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!wr_any && wr_elig[(32'(wr_rr_ptr) + k) % NCH]) begin
        wr_any  = 1'b1;
        wr_pick = CHW'((32'(wr_rr_ptr) + k) % NCH);
      end
      if (!rd_any && rd_elig[(32'(rd_rr_ptr) + k) % NCH]) begin
        rd_any  = 1'b1;
        rd_pick = CHW'((32'(rd_rr_ptr) + k) % NCH);
      end
    end

    for (int unsigned i = 0; i < NCH; i++) begin
      if (wr_pick == CHW'(i)) wr_pick_addr = wr_cur[i];
      if (rd_pick == CHW'(i)) rd_pick_addr = rd_cur[i];
      if (wr_granted[i]) begin
        fin_base   = wr_addr[i*AW +: AW];
        fin_max    = wr_max_addr[i*AW +: AW];
        fin_cur    = wr_cur[i];
        fin_reload = wr_pend[i] | wr_clr[i];
        fin_wrap   = wrap_mode[i];
      end
      if (rd_granted[i]) begin
        fin_base   = rd_addr[i*AW +: AW];
        fin_max    = rd_max_addr[i*AW +: AW];
        fin_cur    = rd_cur[i];
        fin_reload = rd_pend[i] | rd_clr[i];
        fin_wrap   = wrap_mode[i];
      end
    end

    fin_sum = {1'b0, fin_cur} + (AW+1)'(ddr_bus.ddr_len);
    fin_adv = fin_sum < {1'b0, fin_max};
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state              <= IDLE;
      ddr_bus.ddr_wr_req <= 1'b0;
      ddr_bus.ddr_rd_req <= 1'b0;
      ddr_bus.ddr_addr   <= '0;
      ddr_bus.ddr_len    <= '0;
      ddr_bus.ddr_ch     <= '0;
      frame_write_done   <= '0;
      frame_read_done    <= '0;
      wr_load_q          <= '0;
      rd_load_q          <= '0;
      wr_pend            <= '0;
      rd_pend            <= '0;
      wr_rr_ptr          <= '0;
      rd_rr_ptr          <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        wr_cur[i] <= '0;
        rd_cur[i] <= '0;
      end
    end else begin
      wr_load_q <= wr_load;
      rd_load_q <= rd_load;

      // Later assignments in this loop override earlier ones: a finish beats a deferral request.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wrap_mode[i]) begin
          frame_write_done[i] <= 1'b0;
          frame_read_done[i]  <= 1'b0;
        end
        if (wr_clr[i]) begin
          if (wr_granted[i]) wr_pend[i] <= 1'b1;
          else begin
            wr_cur[i]           <= wr_addr[i*AW +: AW];
            frame_write_done[i] <= 1'b0;
          end
        end
        if (rd_clr[i]) begin
          if (rd_granted[i]) rd_pend[i] <= 1'b1;
          else begin
            rd_cur[i]          <= rd_addr[i*AW +: AW];
            frame_read_done[i] <= 1'b0;
          end
        end
        if (wr_granted[i] && ddr_bus.ddr_wr_finish) begin
          wr_pend[i] <= 1'b0;
          if (fin_reload) begin
            wr_cur[i]           <= fin_base;
            frame_write_done[i] <= 1'b0;
          end else if (fin_adv) begin
            wr_cur[i]           <= fin_sum[AW-1:0];
            frame_write_done[i] <= 1'b0;
          end else begin
            if (fin_wrap) wr_cur[i] <= fin_base;
            frame_write_done[i] <= 1'b1;
          end
        end
        if (rd_granted[i] && ddr_bus.ddr_rd_finish) begin
          rd_pend[i] <= 1'b0;
          if (fin_reload) begin
            rd_cur[i]          <= fin_base;
            frame_read_done[i] <= 1'b0;
          end else if (fin_adv) begin
            rd_cur[i]          <= fin_sum[AW-1:0];
            frame_read_done[i] <= 1'b0;
          end else begin
            if (fin_wrap) rd_cur[i] <= fin_base;
            frame_read_done[i] <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: if (ddr_init_done) state <= ARB;
        ARB: begin
          if (!ddr_init_done) begin
            state <= IDLE;
          end else if (wr_any) begin
            state              <= WR_BUSY;
            ddr_bus.ddr_wr_req <= 1'b1;
            ddr_bus.ddr_addr   <= wr_pick_addr;
            ddr_bus.ddr_len    <= wr_length;
            ddr_bus.ddr_ch     <= wr_pick;
            wr_rr_ptr          <= CHW'((32'(wr_pick) + 1) % NCH);
          end else if (rd_any) begin
            state              <= RD_BUSY;
            ddr_bus.ddr_rd_req <= 1'b1;
            ddr_bus.ddr_addr   <= rd_pick_addr;
            ddr_bus.ddr_len    <= rd_length;
            ddr_bus.ddr_ch     <= rd_pick;
            rd_rr_ptr          <= CHW'((32'(rd_pick) + 1) % NCH);
          end
        end
        WR_BUSY: if (ddr_bus.ddr_wr_finish) begin
          ddr_bus.ddr_wr_req <= 1'b0;
          state              <= ARB;
        end
        RD_BUSY: if (ddr_bus.ddr_rd_finish) begin
          ddr_bus.ddr_rd_req <= 1'b0;
          state              <= ARB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_chan_arbiter.sv
// Randomized bench for ddr_chan_arbiter: acts as the DDR controller and predicts every grant,
// burst address and frame-done flag from a transaction-level channel model.
module tb_ddr_chan_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 25;
  localparam int LW  = 10;
  localparam int FW  = 10;

  logic                clk_ref = 1'b0;
  logic                rst = 1'b1;
  logic                ddr_init_done = 1'b0;
  logic [LW-1:0]       wr_length, rd_length;
  logic [NCH-1:0]      wr_load = '0, rd_load = '0, wrap_mode = '0, data_valid = '1;
  logic [NCH-1:0]      frame_write_done, frame_read_done;
  logic [NCH*AW-1:0]   wr_addr, wr_max_addr, rd_addr, rd_max_addr;
  logic [NCH*FW-1:0]   wrf_use, rdf_use;

  logic [AW-1:0] wb [NCH], wm [NCH], rb [NCH], rm [NCH];
  logic [FW-1:0] wf [NCH], rf [NCH];

  // Channel model: current burst address, frame-done flag, round-robin pointers.
  longint m_wa [NCH], m_ra [NCH];
  bit     m_wd [NCH], m_rd [NCH];
  int     m_wp, m_rp;

  int checks = 0;
  int errors = 0;

  ddr_chan_arbiter_if #(.NCH(NCH), .AW(AW), .LW(LW)) bus ();

  ddr_chan_arbiter #(.NCH(NCH), .AW(AW), .LW(LW), .FW(FW)) dut (
    .clk_ref          (clk_ref),
    .rst              (rst),
    .ddr_init_done    (ddr_init_done),
    .wr_length        (wr_length),
    .rd_length        (rd_length),
    .wr_load          (wr_load),
    .rd_load          (rd_load),
    .wr_addr          (wr_addr),
    .wr_max_addr      (wr_max_addr),
    .rd_addr          (rd_addr),
    .rd_max_addr      (rd_max_addr),
    .wrap_mode        (wrap_mode),
    .wrf_use          (wrf_use),
    .rdf_use          (rdf_use),
    .data_valid       (data_valid),
    .ddr_bus          (bus),
    .frame_write_done (frame_write_done),
    .frame_read_done  (frame_read_done)
  );

  always #5 clk_ref = ~clk_ref;

  always_comb begin
    wr_addr = '0; wr_max_addr = '0; rd_addr = '0; rd_max_addr = '0;
    wrf_use = '0; rdf_use = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_addr[i*AW +: AW]     = wb[i];
      wr_max_addr[i*AW +: AW] = wm[i];
      rd_addr[i*AW +: AW]     = rb[i];
      rd_max_addr[i*AW +: AW] = rm[i];
      wrf_use[i*FW +: FW]     = wf[i];
      rdf_use[i*FW +: FW]     = rf[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] pack_done(input bit wr);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = wr ? m_wd[i] : m_rd[i];
    return v;
  endfunction

  // kind: 0 none, 1 write, 2 read
  function automatic void predict(output int kind, output int ch);
    int i;
    kind = 0;
    ch   = 0;
    for (int k = 0; k < NCH; k++) begin
      i = (m_wp + k) % NCH;
      if (kind == 0 && wf[i] >= wr_length && (wrap_mode[i] || !m_wd[i])) begin
        kind = 1; ch = i;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      i = (m_rp + k) % NCH;
      if (kind == 0 && data_valid[i] && rf[i] < rd_length && (wrap_mode[i] || !m_rd[i])) begin
        kind = 2; ch = i;
      end
    end
  endfunction

  function automatic void model_finish(input int kind, input int c, input bit pend);
    longint base, lim, cur, len;
    bit     d;
    if (kind == 1) begin
      base = longint'(wb[c]); lim = longint'(wm[c]); cur = m_wa[c]; len = longint'(wr_length); d = m_wd[c];
    end else begin
      base = longint'(rb[c]); lim = longint'(rm[c]); cur = m_ra[c]; len = longint'(rd_length); d = m_rd[c];
    end
    if (pend) begin
      cur = base; d = 1'b0;
    end else if (cur + len < lim) begin
      cur = cur + len; d = 1'b0;
    end else begin
      if (wrap_mode[c]) cur = base;
      d = 1'b1;
    end
    if (kind == 1) begin m_wa[c] = cur; m_wd[c] = d; end
    else begin m_ra[c] = cur; m_rd[c] = d; end
  endfunction

  // Mode, read-enable and load changes; granted channel changes are deferred to its finish.
  task automatic poke_ctrl(input int gk, input int gc, inout bit pend);
    for (int i = 0; i < NCH; i++) begin
      if ($urandom_range(0, 5) == 0) wrap_mode[i] = ~wrap_mode[i];
      if (wrap_mode[i]) begin m_wd[i] = 1'b0; m_rd[i] = 1'b0; end
      data_valid[i] = ($urandom_range(0, 4) != 0);
      if (!data_valid[i]) begin
        if (gk == 2 && gc == i) pend = 1'b1;
        else begin m_ra[i] = longint'(rb[i]); m_rd[i] = 1'b0; end
      end
      if ($urandom_range(0, 4) == 0) begin
        wr_load[i] = 1'b1;
        if (gk == 1 && gc == i) pend = 1'b1;
        else begin m_wa[i] = longint'(wb[i]); m_wd[i] = 1'b0; end
      end
      if ($urandom_range(0, 4) == 0) begin
        rd_load[i] = 1'b1;
        if (gk == 2 && gc == i) pend = 1'b1;
        else begin m_ra[i] = longint'(rb[i]); m_rd[i] = 1'b0; end
      end
    end
  endtask

  task automatic poke_levels();
    for (int i = 0; i < NCH; i++) begin
      wf[i] = ($urandom_range(0, 2) != 0) ? FW'(32'(wr_length) + $urandom_range(0, 100))
                                          : FW'($urandom_range(0, 32'(wr_length) - 1));
      rf[i] = ($urandom_range(0, 2) != 0) ? FW'($urandom_range(0, 32'(rd_length) - 1))
                                          : FW'(32'(rd_length) + $urandom_range(0, 100));
    end
  endtask

  task automatic levels_off();
    for (int i = 0; i < NCH; i++) begin wf[i] = '0; rf[i] = '1; end
  endtask

  task automatic hold_check(input int k, input int c, input longint ea);
    check("hold_wr_req", 64'(bus.ddr_wr_req), 64'(k == 1));
    check("hold_rd_req", 64'(bus.ddr_rd_req), 64'(k == 2));
    check("hold_ch", 64'(bus.ddr_ch), 64'(c));
    check("hold_addr", 64'(bus.ddr_addr), 64'(ea));
  endtask

  initial begin
    int     k, c, nw;
    bit     pend, dummy, did_rst;
    longint ea;

    bus.ddr_wr_finish = 1'b0;
    bus.ddr_rd_finish = 1'b0;
    did_rst = 1'b0;
    wr_length = LW'(16 << $urandom_range(0, 4));
    rd_length = LW'(16 << $urandom_range(0, 4));
    for (int i = 0; i < NCH; i++) begin
      wb[i] = ($urandom_range(0, 2) == 0) ? '0 : AW'($urandom_range(0, 1 << 20));
      rb[i] = ($urandom_range(0, 2) == 0) ? '0 : AW'($urandom_range(0, 1 << 20));
      wm[i] = wb[i] + AW'(32'(wr_length) * $urandom_range(1, 3) + (($urandom_range(0, 1) != 0) ? 32'(wr_length) / 2 : 0));
      rm[i] = rb[i] + AW'(32'(rd_length) * $urandom_range(1, 3) + (($urandom_range(0, 1) != 0) ? 32'(rd_length) / 2 : 0));
      wrap_mode[i] = 1'($urandom_range(0, 1));
      m_wa[i] = 0; m_ra[i] = 0; m_wd[i] = 1'b0; m_rd[i] = 1'b0;
    end
    m_wp = 0; m_rp = 0;
    levels_off();

    repeat (3) @(negedge clk_ref);
    check("rst_wr_req", 64'(bus.ddr_wr_req), 64'(0));
    check("rst_rd_req", 64'(bus.ddr_rd_req), 64'(0));
    check("rst_addr", 64'(bus.ddr_addr), 64'(0));
    check("rst_len", 64'(bus.ddr_len), 64'(0));
    check("rst_ch", 64'(bus.ddr_ch), 64'(0));
    check("rst_wdone", 64'(frame_write_done), 64'(0));
    check("rst_rdone", 64'(frame_read_done), 64'(0));

    rst = 1'b0;
    wr_load = '1;
    rd_load = '1;
    for (int i = 0; i < NCH; i++) begin m_wa[i] = longint'(wb[i]); m_ra[i] = longint'(rb[i]); end
    @(negedge clk_ref);
    wr_load = '0;
    rd_load = '0;
    poke_levels();
    for (int i = 0; i < NCH; i++) wf[i] = FW'(wr_length);
    repeat (3) begin
      @(negedge clk_ref);
      check("no_req_before_init", 64'({bus.ddr_wr_req, bus.ddr_rd_req}), 64'(0));
    end
    ddr_init_done = 1'b1;
    @(negedge clk_ref);

    for (int it = 0; it < 300; it++) begin
      predict(k, c);
      @(negedge clk_ref);
      if (k == 0) begin
        check("idle_no_req", 64'({bus.ddr_wr_req, bus.ddr_rd_req}), 64'(0));
        levels_off();
        dummy = 1'b0;
        poke_ctrl(0, 0, dummy);
        @(negedge clk_ref);
        check("idle_no_req2", 64'({bus.ddr_wr_req, bus.ddr_rd_req}), 64'(0));
        wr_load = '0;
        rd_load = '0;
        poke_levels();
        continue;
      end

      ea = (k == 1) ? m_wa[c] : m_ra[c];
      check("grant_wr_req", 64'(bus.ddr_wr_req), 64'(k == 1));
      check("grant_rd_req", 64'(bus.ddr_rd_req), 64'(k == 2));
      check("grant_ch", 64'(bus.ddr_ch), 64'(c));
      check("grant_addr", 64'(bus.ddr_addr), 64'(ea));
      check("grant_len", 64'(bus.ddr_len), 64'((k == 1) ? wr_length : rd_length));
      if (k == 1) m_wp = (c + 1) % NCH;
      else        m_rp = (c + 1) % NCH;

      pend = 1'b0;
      poke_ctrl(k, c, pend);
      poke_levels();
      @(negedge clk_ref);
      wr_load = '0;
      rd_load = '0;
      hold_check(k, c, ea);

      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 1) != 0) begin
          if (k == 1) bus.ddr_rd_finish = 1'b1;
          else        bus.ddr_wr_finish = 1'b1;
        end
        @(negedge clk_ref);
        bus.ddr_wr_finish = 1'b0;
        bus.ddr_rd_finish = 1'b0;
        hold_check(k, c, ea);
      end

      if (it >= 100 && !did_rst) begin
        did_rst = 1'b1;
        rst = 1'b1;
        @(negedge clk_ref);
        check("mid_rst_wr_req", 64'(bus.ddr_wr_req), 64'(0));
        check("mid_rst_rd_req", 64'(bus.ddr_rd_req), 64'(0));
        check("mid_rst_addr", 64'(bus.ddr_addr), 64'(0));
        check("mid_rst_len", 64'(bus.ddr_len), 64'(0));
        check("mid_rst_ch", 64'(bus.ddr_ch), 64'(0));
        check("mid_rst_done", 64'({frame_write_done, frame_read_done}), 64'(0));
        rst = 1'b0;
        levels_off();
        if (k == 1) bus.ddr_wr_finish = 1'b1;
        else        bus.ddr_rd_finish = 1'b1;
        @(negedge clk_ref);
        bus.ddr_wr_finish = 1'b0;
        bus.ddr_rd_finish = 1'b0;
        check("post_rst_no_req", 64'({bus.ddr_wr_req, bus.ddr_rd_req}), 64'(0));
        for (int i = 0; i < NCH; i++) begin
          m_wa[i] = 0; m_wd[i] = 1'b0; m_rd[i] = 1'b0;
          m_ra[i] = data_valid[i] ? 0 : longint'(rb[i]);
        end
        m_wp = 0;
        m_rp = 0;
        continue;
      end

      if (k == 1) bus.ddr_wr_finish = 1'b1;
      else        bus.ddr_rd_finish = 1'b1;
      @(negedge clk_ref);
      bus.ddr_wr_finish = 1'b0;
      bus.ddr_rd_finish = 1'b0;
      check("fin_req_low", 64'({bus.ddr_wr_req, bus.ddr_rd_req}), 64'(0));
      model_finish(k, c, pend);
      check("fin_wdone", 64'(frame_write_done), 64'(pack_done(1'b1)));
      check("fin_rdone", 64'(frame_read_done), 64'(pack_done(1'b0)));
      for (int i = 0; i < NCH; i++) begin
        if (wrap_mode[i]) begin m_wd[i] = 1'b0; m_rd[i] = 1'b0; end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
